// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS constants, opcodes and fetch state encoding
package mips_pkg;

  localparam int          MIPS_XLEN        = 32;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_VALID = 2'd2
  } fetch_state_e;

  function automatic logic [5:0] opcode_of(input logic [31:0] instr);
    return instr[31:26];
  endfunction

  function automatic logic [5:0] funct_of(input logic [31:0] instr);
    return instr[5:0];
  endfunction

endpackage

// File: rtl/mips_fetch_unit_if.sv
// rtl/mips_fetch_unit_if.sv - imem and decode-side signals of the fetch unit (fetch_err with FETCH_TIMEOUT_EN)
interface mips_fetch_unit_if;
  import mips_pkg::*;

  logic                 imem_req;
  logic [MIPS_XLEN-1:0] imem_addr;
  logic                 imem_rvalid;
  logic [MIPS_XLEN-1:0] imem_rdata;
  logic [MIPS_XLEN-1:0] instr;
  logic [5:0]           opcode;
  logic [5:0]           funct;
  logic [MIPS_XLEN-1:0] pc;
  logic [MIPS_XLEN-1:0] pc_plus4;
  logic                 instr_valid;
  logic                 instr_ready;
  logic                 branch;
  logic                 zero;
  logic                 jump;
`ifdef FETCH_TIMEOUT_EN
  logic                 fetch_err;
`endif

  modport master (
`ifdef FETCH_TIMEOUT_EN
    output fetch_err,
`endif
    output imem_req, imem_addr, instr, opcode, funct, pc, pc_plus4, instr_valid,
    input  imem_rvalid, imem_rdata, instr_ready, branch, zero, jump
  );

  modport slave (
`ifdef FETCH_TIMEOUT_EN
    input  fetch_err,
`endif
    input  imem_req, imem_addr, instr, opcode, funct, pc, pc_plus4, instr_valid,
    output imem_rvalid, imem_rdata, instr_ready, branch, zero, jump
  );

endinterface

// File: rtl/next_pc_calc.sv
// rtl/next_pc_calc.sv - combinational next-PC selection: jump, taken branch or pc+4
module next_pc_calc
  import mips_pkg::*;
(
  input  logic [31:0] pc_i,
  input  logic [31:0] instr_i,
  input  logic        branch_i,
  input  logic        zero_i,
  input  logic        jump_i,
  output logic [31:0] pc_plus4_o,
  output logic [31:0] next_pc_o
);

  logic [31:0] br_off;
  logic [31:0] target;
  logic        unused_opcode_bits;

  assign pc_plus4_o         = pc_i + 32'd4;
  assign br_off             = {{14{instr_i[15]}}, instr_i[15:0], 2'b00};
  assign unused_opcode_bits = ^instr_i[31:26];

  // jump beats branch; targets are word-aligned regardless of the source bits
  always_comb begin
    target = pc_plus4_o;
    if (jump_i) begin
      target = {pc_plus4_o[31:28], instr_i[25:0], 2'b00};
    end else if (branch_i && zero_i) begin
      target = pc_plus4_o + br_off;
    end
    next_pc_o = target & 32'hFFFF_FFFC;
  end

endmodule

// File: rtl/mips_fetch_unit.sv
// rtl/mips_fetch_unit.sv - fetch stage: one imem read at a time, valid/ready to decode; FETCH_TIMEOUT_EN adds wait timeout
module mips_fetch_unit
  import mips_pkg::*;
#(
  parameter int          XLEN        = MIPS_XLEN,
  parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
  parameter int          TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  mips_fetch_unit_if.master bus
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, instr_q;
  logic [XLEN-1:0] pc_plus4, next_pc;
  logic            capture, handshake, timeout;
  logic            req, valid;

  assign capture   = (state_q == S_WAIT) && bus.imem_rvalid;
  assign handshake = (state_q == S_VALID) && bus.instr_ready;

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             fetch_err_q;

  assign timeout = (state_q == S_WAIT) && !bus.imem_rvalid &&
                   (wait_cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  // counter is zero whenever S_WAIT is entered and advances on each silent cycle
  always_comb begin
    wait_cnt_d = '0;
    if ((state_q == S_WAIT) && !bus.imem_rvalid) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  // wait counter and sticky timeout flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q  <= '0;
      fetch_err_q <= 1'b0;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      fetch_err_q <= fetch_err_q | timeout;
    end
  end

  assign bus.fetch_err = fetch_err_q;
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign timeout = 1'b0;
`endif

  next_pc_calc u_next_pc (
    .pc_i      (pc_q),
    .instr_i   (instr_q),
    .branch_i  (bus.branch),
    .zero_i    (bus.zero),
    .jump_i    (bus.jump),
    .pc_plus4_o(pc_plus4),
    .next_pc_o (next_pc)
  );

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // next state: request lasts one cycle, responses outside S_WAIT are ignored
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        if (capture) begin
          state_d = S_VALID;
        end else if (timeout) begin
          state_d = S_FETCH;
        end
      end
      S_VALID: begin
        if (handshake) begin
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  // outputs: request gated by reset so nothing is issued while held in reset
  always_comb begin
    req   = 1'b0;
    valid = 1'b0;
    case (state_q)
      S_FETCH: req   = rst_n;
      S_VALID: valid = 1'b1;
      default: ;
    endcase
  end

  // held pc/instruction: instr changes only at capture, pc only at handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= {RESET_PC[31:2], 2'b00};
      instr_q <= '0;
    end else begin
      if (capture) begin
        instr_q <= bus.imem_rdata;
      end
      if (handshake) begin
        pc_q <= next_pc;
      end
    end
  end

  assign bus.imem_req    = req;
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = valid;
  assign bus.instr       = instr_q;
  assign bus.opcode      = opcode_of(instr_q);
  assign bus.funct       = funct_of(instr_q);
  assign bus.pc          = pc_q;
  assign bus.pc_plus4    = pc_plus4;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// tb/tb_mips_fetch_unit.sv - self-checking bench for mips_fetch_unit with imem responder and next-pc model
module tb_mips_fetch_unit;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  mips_fetch_unit_if bus ();

  mips_fetch_unit #(
    .XLEN       (32),
    .RESET_PC   (32'h0000_0000),
    .TIMEOUT_CYC(16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_err    = 0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] req_q [$];
  int          lat      = 1;
  bit          silent   = 1'b0;
  bit          spur_req = 1'b0;
  int          req_done = 0;
  int          mem_cnt  = 0;
  logic [31:0] pend_addr;
  int          ncyc     = 0;
  int          req_cyc  = 0;
  int          req_lat  = 1;
  bit          was_valid = 1'b0;
  logic [31:0] exp_pc   = 32'h0;
  logic [31:0] exp_i;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic bound_fail(input string nm);
    n_checks++;
    n_err++;
    $display("FAIL %s: wait bound expired", nm);
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h0123_4000;
  endfunction

  // next address as the fetch rules define it: jump, taken branch, else sequential
  function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] ins,
                                             input logic b, input logic z, input logic j);
    logic [31:0] p4;
    int          off;
    p4 = p + 32'd4;
    if (j) return (p4 & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
    if (b && z) begin
      off = int'($signed(ins[15:0])) * 4;
      return (p4 + 32'(off)) & 32'hFFFF_FFFC;
    end
    return p4;
  endfunction

  // instruction memory: answers each request after lat cycles, drops pending work on reset
  always @(posedge clk) begin
    #1;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    if (!rst_n) begin
      mem_cnt  = 0;
      req_done = req_q.size();
    end else begin
      if (req_q.size() > req_done) begin
        req_done = req_q.size();
        if (!silent) begin
          mem_cnt   = lat;
          pend_addr = req_q[$];
        end
      end
      if (mem_cnt > 0) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          bus.imem_rvalid = 1'b1;
          bus.imem_rdata  = mem_word(pend_addr);
        end
      end
      if (spur_req) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hDEAD_BEEF;
      end
    end
  end

  // per-cycle comparison against the model, sampled mid-cycle
  always @(negedge clk) begin
    ncyc++;
    if (!rst_n) begin
      check("rst_instr_valid", bus.instr_valid, 0);
      check("rst_imem_req", bus.imem_req, 0);
      check("rst_instr", bus.instr, 0);
      check("rst_pc", bus.pc, 32'h0);
      exp_pc    = 32'h0;
      was_valid = 1'b0;
    end else begin
      if (bus.imem_req) begin
        check("req_addr", bus.imem_addr, exp_pc);
        check("req_while_valid", bus.instr_valid, 0);
        req_q.push_back(bus.imem_addr);
        req_cyc = ncyc;
        req_lat = lat;
      end
      if (bus.instr_valid) begin
        exp_i = mem_word(exp_pc);
        if (!was_valid) check("valid_latency", ncyc - req_cyc, req_lat + 1);
        check("instr", bus.instr, exp_i);
        check("pc", bus.pc, exp_pc);
        check("opcode", bus.opcode, exp_i[31:26]);
        check("funct", bus.funct, exp_i[5:0]);
        check("pc_plus4", bus.pc_plus4, exp_pc + 32'd4);
        if (bus.instr_ready) exp_pc = model_next(exp_pc, exp_i, bus.branch, bus.zero, bus.jump);
      end
      was_valid = bus.instr_valid;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_valid();
    for (int k = 0; k < 60 && !bus.instr_valid; k++) cyc();
    if (!bus.instr_valid) bound_fail("wait_instr_valid");
  endtask

  task automatic wait_req(input int n);
    for (int k = 0; k < 30 && req_q.size() <= n; k++) cyc();
    if (req_q.size() <= n) bound_fail("wait_imem_req");
  endtask

  task automatic hs(input logic b, input logic z, input logic j);
    wait_valid();
    bus.branch      = b;
    bus.zero        = z;
    bus.jump        = j;
    bus.instr_ready = 1'b1;
    cyc();
    bus.instr_ready = 1'b0;
    bus.branch      = 1'b0;
    bus.zero        = 1'b0;
    bus.jump        = 1'b0;
  endtask

  task automatic hs_expect(input string nm, input logic b, input logic z, input logic j,
                           input logic [31:0] addr);
    int n;
    n = req_q.size();
    hs(b, z, j);
    wait_req(n);
    if (req_q.size() > n) check(nm, req_q[n], addr);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    mem[32'h0000_0010] = 32'h1000_0003;
    mem[32'h0000_0024] = 32'h0800_0004;
    mem[32'h0000_0014] = 32'h0800_0040;
    mem[32'h0000_0100] = 32'h0800_0040;
    mem[32'h0000_0104] = 32'h1000_FFBD;

    rst_n           = 1'b0;
    bus.instr_ready = 1'b0;
    bus.branch      = 1'b0;
    bus.zero        = 1'b0;
    bus.jump        = 1'b0;
    repeat (3) cyc();
    check("reset_pc_lit", bus.pc, 32'h0);
    check("reset_valid_lit", bus.instr_valid, 0);
`ifdef FETCH_TIMEOUT_EN
    check("reset_fetch_err", bus.fetch_err, 0);
`endif
    rst_n = 1'b1;

    hs(0, 0, 0);
    hs(0, 0, 0);
    wait_req(2);
    if (req_q.size() > 2) begin
      check("first_addr0", req_q[0], 32'h0);
      check("first_addr1", req_q[1], 32'h4);
      check("first_addr2", req_q[2], 32'h8);
    end
    hs_expect("seq_0c", 0, 0, 0, 32'h0000_000C);
    hs_expect("seq_10", 0, 0, 0, 32'h0000_0010);
    hs_expect("beq_taken", 1, 1, 0, 32'h0000_0020);
    hs_expect("seq_24", 0, 0, 0, 32'h0000_0024);
    hs_expect("jump_back", 0, 0, 1, 32'h0000_0010);
    hs_expect("beq_not_taken", 1, 0, 0, 32'h0000_0014);
    hs_expect("jump_over_branch", 1, 1, 1, 32'h0000_0100);

    wait_valid();
    n = req_q.size();
    for (int i = 0; i < 5; i++) begin
      spur_req = (i == 1);
      cyc();
    end
    spur_req = 1'b0;
    check("stall_instr", bus.instr, 32'h0800_0040);
    check("stall_pc", bus.pc, 32'h0000_0100);
    check("stall_opcode", bus.opcode, OP_J);
    check("stall_valid", bus.instr_valid, 1);
    check("stall_no_req", req_q.size(), n);

    hs_expect("jump_at_100", 1, 1, 1, 32'h0000_0100);
    hs_expect("seq_104", 0, 0, 0, 32'h0000_0104);
    hs_expect("branch_to_top", 1, 1, 0, 32'hFFFF_FFFC);
    hs_expect("wrap_to_zero", 0, 0, 0, 32'h0000_0000);

    wait_valid();
    lat = 4;
    n = req_q.size();
    hs(0, 0, 0);
    cyc();
    cyc();
    rst_n = 1'b0;
    #1;
    check("midreset_valid", bus.instr_valid, 0);
    check("midreset_req", bus.imem_req, 0);
    check("midreset_pc", bus.pc, 32'h0);
    cyc();
    cyc();
    lat   = 1;
    rst_n = 1'b1;
    n = req_q.size();
    wait_req(n);
    if (req_q.size() > n) check("post_reset_addr", req_q[n], 32'h0);
    wait_valid();
    check("post_reset_instr", bus.instr, mem_word(32'h0));

`ifdef FETCH_TIMEOUT_EN
    silent = 1'b1;
    n = req_q.size();
    hs(0, 0, 0);
    for (int k = 0; k < 40 && !bus.fetch_err; k++) cyc();
    if (!bus.fetch_err) bound_fail("wait_fetch_err");
    silent = 1'b0;
    cyc();
    check("timeout_req_count", req_q.size(), n + 2);
    if (req_q.size() > n + 1) check("timeout_reissue_addr", req_q[n + 1], 32'h4);
    wait_valid();
    check("timeout_recover_pc", bus.pc, 32'h4);
    check("fetch_err_sticky", bus.fetch_err, 1);
`endif

    hs(0, 0, 0);
    hs(0, 0, 0);
    wait_valid();
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
